// File: rtl/line_buffer_pkg.sv
// Shared constants and helpers for the conv front-end line buffer and window stage.
package line_buffer_pkg;

  localparam int WORDWIDTH_DEF = 32;
  localparam int FIG_WIDTH_DEF = 28;
  localparam int FIG_HEIGHT_DEF = 28;
  localparam int KROWS_DEF = 3;

  // Counter width for a count range of n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bit offset of lane k inside a packed column of width-bit pixels.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/line_ram.sv
// One stored image row: single-port RAM, write on clock, asynchronous read.
// A same-cycle read returns the word that is about to be overwritten.
module line_ram #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/line_buffer_kxn.sv
// KROWS-row line buffer: emits one vertical pixel column per accepted pixel,
// with per-frame warm-up, one-deep output register and column/row tags.
module line_buffer_kxn
  import line_buffer_pkg::*;
#(
  parameter int WORDWIDTH  = WORDWIDTH_DEF,
  parameter int FIG_WIDTH  = FIG_WIDTH_DEF,
  parameter int FIG_HEIGHT = FIG_HEIGHT_DEF,
  parameter int KROWS      = KROWS_DEF,
  parameter int COLW       = cnt_width(FIG_WIDTH),
  parameter int ROWW       = cnt_width(FIG_HEIGHT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_restart,
  input  logic [WORDWIDTH-1:0]       din,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [KROWS*WORDWIDTH-1:0] dout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COLW-1:0]            out_col,
  output logic [ROWW-1:0]            out_row,
  output logic                       out_last
);

  localparam int NRAM = KROWS - 1;

  logic [COLW-1:0]            col_cnt;
  logic [ROWW-1:0]            row_cnt;
  logic [WORDWIDTH-1:0]       ram_rd [NRAM];
  logic [WORDWIDTH-1:0]       ram_wr [NRAM];
  logic [KROWS*WORDWIDTH-1:0] col_next;
  logic                       accept;
  logic                       wr_en;
  logic                       col_end;
  logic                       row_end;
  logic                       warm;

  // A restart drops the pixel offered in the same cycle, so refuse it.
  assign in_ready = (~out_valid | out_ready) & ~frame_restart;
  assign accept   = in_valid & in_ready;
  assign wr_en    = accept & ~rst;

  assign col_end = (col_cnt == COLW'(FIG_WIDTH - 1));
  assign row_end = (row_cnt == ROWW'(FIG_HEIGHT - 1));
  assign warm    = (row_cnt >= ROWW'(KROWS - 1));

  // RAM j holds row r-1-j; on each accept every row shifts one RAM deeper.
  for (genvar j = 0; j < NRAM; j++) begin : g_ram
    if (j == 0) begin : g_head
      assign ram_wr[j] = din;
    end else begin : g_chain
      assign ram_wr[j] = ram_rd[j-1];
    end

    line_ram #(
      .DEPTH (FIG_WIDTH),
      .WIDTH (WORDWIDTH),
      .AW    (COLW)
    ) u_line_ram (
      .clk   (clk),
      .we    (wr_en),
      .addr  (col_cnt),
      .wdata (ram_wr[j]),
      .rdata (ram_rd[j])
    );
  end

  always_comb begin
    col_next = '0;
    col_next[lane_lsb(KROWS-1, WORDWIDTH) +: WORDWIDTH] = din;
    for (int j = 0; j < NRAM; j++) begin
      col_next[lane_lsb(KROWS-2-j, WORDWIDTH) +: WORDWIDTH] = ram_rd[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      out_col   <= '0;
      out_row   <= '0;
      out_last  <= 1'b0;
    end else if (frame_restart) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      dout      <= col_next;
      out_col   <= col_cnt;
      out_row   <= row_cnt;
      out_last  <= col_end & row_end;
      out_valid <= warm;
      if (col_end) begin
        col_cnt <= '0;
        row_cnt <= row_end ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_buffer_kxn.sv
// Directed bench for line_buffer_kxn at 4x4 frames, 3-row kernel.
module tb_line_buffer_kxn;

  localparam int WW = 32;
  localparam int FW = 4;
  localparam int FH = 4;
  localparam int KR = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             frame_restart;
  logic [WW-1:0]    din;
  logic             in_valid;
  logic             in_ready;
  logic [KR*WW-1:0] dout;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_col;
  logic [1:0]       out_row;
  logic             out_last;

  int n_tests = 0;
  int n_fail  = 0;

  line_buffer_kxn #(
    .WORDWIDTH  (WW),
    .FIG_WIDTH  (FW),
    .FIG_HEIGHT (FH),
    .KROWS      (KR),
    .COLW       (2),
    .ROWW       (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_restart (frame_restart),
    .din           (din),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .dout          (dout),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_col       (out_col),
    .out_row       (out_row),
    .out_last      (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] px(input int base, input int r, input int c);
    return WW'(base + 16*r + c);
  endfunction

  // lane 0 = row r-2, lane 1 = row r-1, lane 2 = row r
  function automatic logic [95:0] exp_col(input int base, input int r, input int c);
    return {px(base, r, c), px(base, r-1, c), px(base, r-2, c)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic vld, input int base,
                            input int r, input int c);
    chk({tag, ".valid"}, 96'(out_valid), 96'(vld));
    if (vld) begin
      chk({tag, ".dout"}, dout, exp_col(base, r, c));
      chk({tag, ".col"},  96'(out_col), 96'(c));
      chk({tag, ".row"},  96'(out_row), 96'(r));
      chk({tag, ".last"}, 96'(out_last), 96'((r == FH-1) && (c == FW-1)));
    end
  endtask

  // Back-to-back pixels p_from..p_to of one frame, downstream always ready.
  task automatic stream(input string tag, input int base, input int p_from, input int p_to);
    for (int p = p_from; p <= p_to; p++) begin
      din      = px(base, p / FW, p % FW);
      in_valid = 1'b1;
      #1;
      chk({tag, ".in_ready"}, 96'(in_ready), 96'(1));
      tick();
      expect_out(tag, p >= FW*(KR-1), base, p / FW, p % FW);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    frame_restart = 1'b0;
    din           = '0;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset.valid",    96'(out_valid), 96'(0));
    chk("reset.dout",     dout, 96'(0));
    chk("reset.col",      96'(out_col), 96'(0));
    chk("reset.row",      96'(out_row), 96'(0));
    chk("reset.last",     96'(out_last), 96'(0));
    chk("reset.in_ready", 96'(in_ready), 96'(1));

    // Frame A: warm-up then streaming up to row 2 col 1
    stream("warm", 0, 0, 9);

    // Hold (2,1) for three cycles with the next pixel offered
    out_ready = 1'b0;
    din       = px(0, 2, 2);
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.in_ready", 96'(in_ready), 96'(0));
      tick();
      expect_out("stall", 1'b1, 0, 2, 1);
    end
    out_ready = 1'b1;
    stream("release", 0, 10, 15);

    // Frame B: fresh data must warm up again, then sparse input
    stream("frame2.warm", 'h100, 0, 7);
    for (int p = 8; p < 16; p++) begin
      din      = px('h100, p / FW, p % FW);
      in_valid = 1'b1;
      tick();
      expect_out("sparse", 1'b1, 'h100, p / FW, p % FW);
      in_valid = 1'b0;
      tick();
      chk("sparse.gap", 96'(out_valid), 96'(0));
    end

    // Frame C interrupted by frame_restart right after row 2 col 1
    stream("pre_restart", 'h200, 0, 9);
    out_ready     = 1'b0;
    frame_restart = 1'b1;
    din           = px('h200, 2, 2);
    in_valid      = 1'b1;
    #1;
    chk("restart.in_ready", 96'(in_ready), 96'(0));
    tick();
    frame_restart = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    chk("restart.valid", 96'(out_valid), 96'(0));
    stream("post_restart", 'h300, 0, 13);

    // rst mid row 3 while an output is pending
    chk("pre_rst.valid", 96'(out_valid), 96'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst.valid",    96'(out_valid), 96'(0));
    chk("rst.dout",     dout, 96'(0));
    chk("rst.in_ready", 96'(in_ready), 96'(1));
    stream("post_rst", 'h400, 0, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buffer_kxn.md
Name: line_buffer_kxn

Overview:
- Parametrised multi-row line buffer for the conv front end; replaces the single-row FIFO line delay.
- Holds the last KROWS-1 image rows in inferred RAMs. For each accepted pixel it emits a vertical column of KROWS pixels from the same image column, feeding the window/systolic input stage.
- Adds what the single-row version lacks: arbitrary kernel height, frame-height tracking with automatic re-warm-up per frame, downstream back-pressure, column/row tags, and a synchronous frame restart.

Parameters:
- WORDWIDTH, 32, pixel width in bits
- FIG_WIDTH, 28, pixels per row (>=2)
- FIG_HEIGHT, 28, rows per frame (>=KROWS)
- KROWS, 3, kernel height = lanes in output column (>=2)
- COLW, $clog2(FIG_WIDTH), column counter width
- ROWW, $clog2(FIG_HEIGHT), row counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- frame_restart  in  1  synchronous counter clear (RAM contents kept)
- din  in  WORDWIDTH  input pixel, raster order
- in_valid  in  1  din valid
- in_ready  out  1  block can accept din
- dout  out  KROWS*WORDWIDTH  column; lane k = dout[k*WORDWIDTH +: WORDWIDTH]; lane 0 = oldest row, lane KROWS-1 = newest pixel
- out_valid  out  1  dout valid
- out_ready  in  1  downstream accepts dout
- out_col  out  COLW  image column of dout
- out_row  out  ROWW  image row of the newest lane
- out_last  out  1  dout is the final column of the frame (row FIG_HEIGHT-1, col FIG_WIDTH-1)

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high on rst. Port names are clk / rst.
- Reset values: out_valid=0, dout=0, out_col=0, out_row=0, out_last=0, col_cnt=0, row_cnt=0. in_ready is 1 in the first cycle after reset. RAM contents are not reset.
- Handshakes: in_ready = ~out_valid | out_ready (combinational, one-deep output register). Input accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
- On accept:
  - For each RAM j (0..KROWS-2), read old data at address col_cnt. RAM 0 holds row r-1, RAM j holds row r-1-j.
  - Write RAM 0 <= din and RAM j <= old RAM j-1 data, all at col_cnt, in the same cycle (read-old-data semantics).
  - Register lanes: lane KROWS-1 = din; lane KROWS-2-j = old RAM j data.
  - out_col <= col_cnt, out_row <= row_cnt.
- Latency: exactly 1 cycle from accept to out_valid.
- Warm-up:
  - out_valid <= 1 on accept only if row_cnt >= KROWS-1.
  - Pixels of rows 0..KROWS-2 are stored but produce no output.
  - out_valid clears on transfer when no new valid accept occurs in the same cycle.
- Stall: while out_valid & ~out_ready, dout and its tags hold stable and no input is accepted.
- Simultaneous transfer and accept: the register is reloaded in the same cycle, giving zero bubbles at full throughput.
- Counters:
  - col_cnt increments per accept and wraps FIG_WIDTH-1 -> 0, incrementing row_cnt.
  - row_cnt wraps FIG_HEIGHT-1 -> 0 after the last pixel of the frame, so the next frame warms up again with no output until its row KROWS-1.
- out_last = 1 with the column where out_row=FIG_HEIGHT-1 and out_col=FIG_WIDTH-1.
- frame_restart:
  - Clears col_cnt, row_cnt and out_valid next cycle; any pending output is dropped.
  - Has priority over a same-cycle accept; that pixel is discarded, so in_ready is driven 0 during frame_restart.
- rst mid-frame: same effect as frame_restart plus output registers cleared. No stale column is emitted after reset, because warm-up refills every lane before it is used.
- Widths: counters are unsigned; no arithmetic on pixel data.

Decomposition:
- Shared package/header line_buffer_pkg:
  - lane-select helper macro/function
  - COLW/ROWW clog2 derivation
  - default WORDWIDTH / FIG_WIDTH constants, shared with the window stage
- Sub-module line_ram: single-port, depth FIG_WIDTH, width WORDWIDTH, write-enable, asynchronous read or registered read with read-old-data semantics. Instantiated KROWS-1 times in a generate loop.

Test Plan:
All scenarios use FIG_WIDTH=4, FIG_HEIGHT=4, KROWS=3, din=16*row+col.
1. Warm-up and streaming, in_valid=1 continuously, out_ready=1:
   - no out_valid during first 8 accepts
   - 9th accept (row2,col0) -> next cycle dout lanes {0x00,0x10,0x20}, out_col=0, out_row=2
   - continuous out_valid for 8 cycles
2. Back-pressure, out_ready=0 for 3 cycles while showing {0x01,0x11,0x21}:
   - dout/out_col hold, in_ready=0
   - on release, next column {0x02,0x12,0x22} follows with no gaps or duplicates
3. Frame end and second frame:
   - out_last=1 only on {0x23,0x33,0x43}/col3 row3... i.e. lanes {0x13,0x23,0x33}
   - second frame gives no output until its row 2
   - first output is {0x00,0x10,0x20} built from new data only
4. Sparse input (in_valid toggling 1/0):
   - every output exactly 1 cycle after its accept
   - out_col sequence 0,1,2,3 per row
5. frame_restart asserted after row2,col1 accept, same cycle as in_valid:
   - in_ready=0 during restart, that pixel dropped
   - out_valid=0 next cycle
   - counters at 0; output resumes only after 8 new warm-up pixels
6. rst pulse mid-row 3 with out_valid=1:
   - out_valid=0 and dout=0 next cycle, in_ready=1
   - restart behaves as in scenario 1
